mem_req_queue: RTL

//  Parametrised EXE-to-MEM data-memory access unit. Issues loads and stores on the

---
 rtl/mem_req_queue.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_req_queue.sv
// EXE-to-MEM data-memory access unit: issues loads/stores on an sram-like
// req/addr_ok/data_ok bus and keeps up to DEPTH outstanding accesses in order.
module mem_req_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wr,
    input  logic [1:0]          in_size,
    input  logic                in_sign,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [4:0]          in_rd,
    input  logic                flush,
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [1:0]          data_sram_size,
    output logic [DATA_W/8-1:0] data_sram_wstrb,
    output logic [ADDR_W-1:0]   data_sram_addr,
    output logic [DATA_W-1:0]   data_sram_wdata,
    input  logic                data_sram_addr_ok,
    input  logic                data_sram_data_ok,
    input  logic [DATA_W-1:0]   data_sram_rdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_wr,
    output logic                resp_ale,
    output logic [4:0]          resp_rd,
    output logic [ADDR_W-1:0]   resp_addr,
    output logic [DATA_W-1:0]   resp_data
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0]             wr_q, sign_q, ale_q, done_q, cancel_q;
    logic [DEPTH-1:0][1:0]        size_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][4:0]        rd_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PW-1:0]                head_q, tail_q;
    logic [CW-1:0]                count_q, count_d;

    logic              ale, full, acc, pop, pending, done_ok, msb;
    logic [PW-1:0]     dsel, sidx;
    logic [OW-1:0]     off, doff;
    logic [NB-1:0]     strb;
    logic [DATA_W-1:0] rep, sh, ext;
    int                nb;

    always_comb begin
        ale = 1'b0;
        case (in_size)
            2'd1:    ale = in_addr[0];
            2'd2:    ale = |in_addr[1:0];
            2'd3:    ale = (DATA_W == 32) || (|in_addr[2:0]);
            default: ale = 1'b0;
        endcase
    end

    assign full     = (count_q == FULL_CNT);
    assign in_ready = ~full & ~flush & (ale | data_sram_addr_ok);
    assign acc      = in_valid & in_ready;
    assign off      = in_addr[OW-1:0];

    always_comb begin
        strb = '1;
        case (in_size)
            2'd0:    strb = NB'(1) << off;
            2'd1:    strb = NB'(3) << off;
            2'd2:    strb = NB'(15) << off;
            default: strb = '1;
        endcase
    end

    // Store data is right-aligned; copy the low size-bytes into every lane.
    always_comb begin
        rep = '0;
        for (int b = 0; b < NB; b++) begin
            case (in_size)
                2'd0:    rep[b*8 +: 8] = in_wdata[7:0];
                2'd1:    rep[b*8 +: 8] = in_wdata[(b%2)*8 +: 8];
                2'd2:    rep[b*8 +: 8] = in_wdata[(b%4)*8 +: 8];
                default: rep[b*8 +: 8] = in_wdata[b*8 +: 8];
            endcase
        end
    end

    assign data_sram_req   = in_valid & ~ale & ~full & ~flush;
    assign data_sram_wr    = in_valid & in_wr;
    assign data_sram_size  = in_valid ? in_size : 2'd0;
    assign data_sram_addr  = in_valid ? in_addr : '0;
    assign data_sram_wstrb = (in_valid & in_wr) ? strb : '0;
    assign data_sram_wdata = in_valid ? rep : '0;

    // Data pointer: oldest live entry still waiting on the bus. ALE entries are
    // born done, so they are skipped naturally.
    always_comb begin
        pending = 1'b0;
        dsel    = '0;
        sidx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sidx = head_q + PW'(k);
            if (!pending && (CW'(k) < count_q) && !done_q[sidx]) begin
                pending = 1'b1;
                dsel    = sidx;
            end
        end
    end

    assign done_ok = data_sram_data_ok & pending;
    assign doff    = addr_q[dsel][OW-1:0];
    assign sh      = data_sram_rdata >> {doff, 3'b000};

    always_comb begin
        nb  = DATA_W;
        msb = sh[DATA_W-1];
        case (size_q[dsel])
            2'd0:    begin nb = 8;  msb = sh[7];  end
            2'd1:    begin nb = 16; msb = sh[15]; end
            2'd2:    begin nb = 32; msb = sh[31]; end
            default: begin nb = DATA_W; msb = sh[DATA_W-1]; end
        endcase
        ext = '0;
        for (int b = 0; b < DATA_W; b++)
            ext[b] = (b < nb) ? sh[b] : (sign_q[dsel] & msb);
    end

    assign resp_valid = (count_q != '0) & done_q[head_q] & ~cancel_q[head_q];
    assign pop        = (count_q != '0) & done_q[head_q] & (cancel_q[head_q] | resp_ready);
    assign resp_wr    = wr_q[head_q];
    assign resp_ale   = ale_q[head_q];
    assign resp_rd    = rd_q[head_q];
    assign resp_addr  = addr_q[head_q];
    assign resp_data  = data_q[head_q];

    always_comb begin
        count_d = count_q;
        case ({acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wr_q     <= '0;
            sign_q   <= '0;
            ale_q    <= '0;
            done_q   <= '0;
            cancel_q <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            // Flush never coincides with an allocation, so marking every slot is safe.
            if (flush)
                cancel_q <= '1;
            if (done_ok) begin
                done_q[dsel] <= 1'b1;
                data_q[dsel] <= wr_q[dsel] ? '0 : ext;
            end
            if (acc) begin
                wr_q[tail_q]     <= in_wr;
                sign_q[tail_q]   <= in_sign;
                ale_q[tail_q]    <= ale;
                done_q[tail_q]   <= ale;
                cancel_q[tail_q] <= 1'b0;
                size_q[tail_q]   <= in_size;
                addr_q[tail_q]   <= in_addr;
                rd_q[tail_q]     <= in_rd;
                data_q[tail_q]   <= '0;
                tail_q           <= tail_q + PW'(1);
            end
            if (pop)
                head_q <= head_q + PW'(1);
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    a_data_ok_pending: assert property (@(posedge clk) disable iff (reset)
        data_sram_data_ok |-> pending)
        else $error("data_ok with no outstanding request");
`endif

endmodule
